pcs_10g_tx_gearbox: RTL and testbench

TX 64b/66b gearbox and its sequencer for the 10G PCS. It sits between the PCS TX encoder/scrambler output and the 64-bit SerDes parallel interface. It accepts one 66-bit block (2-bit sync header plus 64-bit payload) per accepted cycle and emits a continuous 64-bit word stream. To absorb the 66/64 rate difference, it pauses the encoder for one cycle in every 33.

---
 rtl/pcs_10g_pkg.sv | 20 ++
 rtl/pcs_10g_gearbox_seq.sv | 36 +++
 rtl/pcs_10g_tx_gearbox.sv | 111 +++++++++++
 tb/tb_pcs_10g_tx_gearbox.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_10g_pkg.sv
// Shared 10G PCS constants and types used by the TX/RX gearboxes.
package pcs_10g_pkg;

    localparam int PCS_BLOCK_W = 66;
    localparam int PCS_HEAD_W  = 2;
    localparam int GB_SEQ_W    = 6;

    localparam logic [GB_SEQ_W-1:0] GB_SEQ_MAX = 6'd32;

    // Sync headers as stored in head[1:0]; bit 0 goes on the wire first.
    localparam logic [PCS_HEAD_W-1:0] SYNC_DATA = 2'b10;
    localparam logic [PCS_HEAD_W-1:0] SYNC_CTRL = 2'b01;

    typedef enum logic [1:0] {
        GB_STALL  = 2'd0,
        GB_ACCEPT = 2'd1,
        GB_DRAIN  = 2'd2
    } gb_mode_e;

endpackage

// File: rtl/pcs_10g_gearbox_seq.sv
// 0..GB_SEQ_MAX gearbox sequence counter; ready is low only on the drain slot.
module pcs_10g_gearbox_seq
    import pcs_10g_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                step_i,
    output logic [GB_SEQ_W-1:0] seq_o,
    output logic                ready_o
);

    logic [GB_SEQ_W-1:0] seq_q;
    logic [GB_SEQ_W-1:0] seq_d;

    // The drain slot always wraps to 0, whether or not a step is requested.
    always_comb begin
        seq_d = seq_q;
        if (seq_q == GB_SEQ_MAX) begin
            seq_d = '0;
        end else if (step_i) begin
            seq_d = seq_q + GB_SEQ_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign seq_o   = seq_q;
    assign ready_o = (seq_q != GB_SEQ_MAX);

endmodule

// File: rtl/pcs_10g_tx_gearbox.sv
// 66b-to-64b TX gearbox: packs one 66-bit block per accepted cycle into a
// continuous 64-bit SerDes stream, stalling the encoder one cycle in 33.
module pcs_10g_tx_gearbox
    import pcs_10g_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int HEAD_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              data_v_o,
    output logic [DATA_W-1:0] data_o,
    output logic [5:0]        seq_o,
    output logic              underflow_o
);

    localparam int BLK_W = DATA_W + HEAD_W;
    localparam logic [GB_SEQ_W:0] SHIFT_FULL = (GB_SEQ_W + 1)'(DATA_W);

    logic [GB_SEQ_W-1:0] seq;
    logic                seq_ready;
    gb_mode_e            mode;

    logic [BLK_W-1:0]    blk;
    logic [GB_SEQ_W:0]   shift;
    logic [DATA_W-1:0]   res_mask;

    logic [DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                data_v_q, data_v_d;
    logic [5:0]          seq_out_q, seq_out_d;
    logic                underflow_q, underflow_d;

    pcs_10g_gearbox_seq u_seq (
        .clk     (clk),
        .reset   (reset),
        .step_i  (valid_i),
        .seq_o   (seq),
        .ready_o (seq_ready)
    );

    assign blk      = {data_i, head_i};
    assign shift    = {seq, 1'b0};
    assign res_mask = ~({DATA_W{1'b1}} << shift);

    always_comb begin
        if (!seq_ready) begin
            mode = GB_DRAIN;
        end else if (valid_i) begin
            mode = GB_ACCEPT;
        end else begin
            mode = GB_STALL;
        end
    end

    // Accept: low part of the block sits above the r residue bits; the top
    // r+2 block bits become the new residue via the complementary shift.
    always_comb begin
        res_d       = res_q;
        data_d      = data_q;
        data_v_d    = 1'b0;
        seq_out_d   = seq_out_q;
        underflow_d = underflow_q;
        case (mode)
            GB_ACCEPT: begin
                data_d    = DATA_W'(blk << shift) | (res_q & res_mask);
                res_d     = DATA_W'(blk >> (SHIFT_FULL - shift));
                data_v_d  = 1'b1;
                seq_out_d = seq;
            end
            GB_DRAIN: begin
                data_d    = res_q;
                res_d     = '0;
                data_v_d  = 1'b1;
                seq_out_d = seq;
            end
            GB_STALL: begin
                underflow_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q       <= '0;
            data_q      <= '0;
            data_v_q    <= 1'b0;
            seq_out_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            data_q      <= data_d;
            data_v_q    <= data_v_d;
            seq_out_q   <= seq_out_d;
            underflow_q <= underflow_d;
        end
    end

    assign ready_o     = seq_ready;
    assign data_v_o    = data_v_q;
    assign data_o      = data_q;
    assign seq_o       = seq_out_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_pcs_10g_tx_gearbox.sv
// Bench for pcs_10g_tx_gearbox: bit-queue stream model with a word scoreboard,
// a short vector table, and directed multi-cycle sequences.
module tb_pcs_10g_tx_gearbox;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic [1:0]  head_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic        data_v_o;
    logic [63:0] data_o;
    logic [5:0]  seq_o;
    logic        underflow_o;

    pcs_10g_tx_gearbox #(.DATA_W(64), .HEAD_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (valid_i),
        .head_i      (head_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .data_v_o    (data_v_o),
        .data_o      (data_o),
        .seq_o       (seq_o),
        .underflow_o (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic [5:0]  seq;
    } sb_t;

    typedef struct {
        logic        valid;
        logic [1:0]  head;
        logic [63:0] data;
        logic        exp_ready;
        logic        exp_v;
        logic [63:0] exp_data;
        logic [5:0]  exp_seq;
        logic        exp_uflow;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    bit          bitq[$];
    sb_t         sb[$];
    int          m_seq;
    logic        m_uflow;
    logic [63:0] last_word;
    logic        out_v;
    logic [63:0] out_word;
    logic [5:0]  out_seq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pop_word();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 64; i++) begin
            if (bitq.size() > 0) w[i] = bitq.pop_front();
        end
        return w;
    endfunction

    // Called at posedge+1; resets asynchronously mid-cycle and releases at posedge+1.
    task automatic do_reset();
        valid_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_data", data_o, 64'h0);
        check("rst_data_v", data_v_o, 1'b0);
        check("rst_seq", seq_o, 6'd0);
        check("rst_uflow", underflow_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        bitq.delete();
        sb.delete();
        m_seq     = 0;
        m_uflow   = 1'b0;
        last_word = '0;
    endtask

    // One clock: drive inputs, predict with the model, then check outputs.
    task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d);
        logic        exp_v;
        logic [65:0] blk;
        sb_t         e;
        blk     = {d, h};
        valid_i = v;
        head_i  = h;
        data_i  = d;
        exp_v   = 1'b1;
        check("ready", ready_o, (m_seq != 32));
        if (m_seq == 32) begin
            e.word = pop_word();
            e.seq  = 6'd32;
            sb.push_back(e);
            m_seq = 0;
        end else if (v) begin
            for (int b = 0; b < 66; b++) bitq.push_back(blk[b]);
            e.word = pop_word();
            e.seq  = 6'(m_seq);
            sb.push_back(e);
            m_seq++;
        end else begin
            exp_v   = 1'b0;
            m_uflow = 1'b1;
        end
        @(posedge clk);
        #1;
        out_v    = data_v_o;
        out_word = data_o;
        out_seq  = seq_o;
        check("data_v", data_v_o, exp_v);
        if (data_v_o) begin
            if (sb.size() == 0) begin
                check("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("data", data_o, e.word);
                check("seq_o", seq_o, e.seq);
                last_word = e.word;
            end
        end else begin
            check("data_hold", data_o, last_word);
        end
        check("underflow", underflow_o, m_uflow);
    endtask

    vec_t        vecs[4];
    logic [2111:0] got_stream;
    logic [2111:0] exp_stream;
    logic [63:0] tmp;
    logic [63:0] blkd;
    int          w;

    initial begin
        vecs[0] = '{1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 6'd0, 1'b0};
        vecs[1] = '{1'b0, 2'b01, 64'h0,                   1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 6'd0, 1'b1};
        vecs[2] = '{1'b1, 2'b01, 64'h0,                   1'b1, 1'b1, 64'h0000_0000_0000_0007, 6'd1, 1'b1};
        vecs[3] = '{1'b1, 2'b10, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1'b1, 64'h6969_6969_6969_6960, 6'd2, 1'b1};

        reset   = 1'b1;
        valid_i = 1'b0;
        head_i  = '0;
        data_i  = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Vector table: single block, underflow gap, residue carry-over.
        for (int i = 0; i < 4; i++) begin
            check("tbl_ready", ready_o, vecs[i].exp_ready);
            step(vecs[i].valid, vecs[i].head, vecs[i].data);
            check("tbl_data_v", out_v, vecs[i].exp_v);
            check("tbl_data", out_word, vecs[i].exp_data);
            check("tbl_seq", out_seq, vecs[i].exp_seq);
            check("tbl_uflow", underflow_o, vecs[i].exp_uflow);
        end

        // Continuous valid: ready low exactly on cycles 32, 65, 98.
        do_reset();
        for (int c = 0; c < 100; c++) begin
            check("ready_pattern", ready_o, ((c % 33) != 32));
            step(1'b1, 2'b01, 64'h0);
            check("cont_data_v", out_v, 1'b1);
        end

        // Ramp: 33 words must reproduce {blk31..blk0} LSB-first.
        do_reset();
        w = 0;
        got_stream = '0;
        for (int i = 0; i < 32; i++) begin
            exp_stream[i*66 +: 66] = {64'(i), 2'b01};
            step(1'b1, 2'b01, 64'(i));
            if (out_v && w < 33) begin
                got_stream[w*64 +: 64] = out_word;
                w++;
            end
        end
        step(1'b0, 2'b01, 64'h0);
        if (out_v && w < 33) begin
            got_stream[w*64 +: 64] = out_word;
            w++;
        end
        check("ramp_words", 64'(w), 64'd33);
        check("ramp_drain_seq", out_seq, 6'd32);
        for (int k = 0; k < 33; k++) begin
            check("ramp_stream", got_stream[k*64 +: 64], exp_stream[k*64 +: 64]);
        end

        // Underflow at seq 10: one idle word, seq resumes, flag sticks.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 2'b10, {$urandom, $urandom});
        step(1'b0, 2'b10, 64'h0);
        check("uf_gap_v", out_v, 1'b0);
        check("uf_flag", underflow_o, 1'b1);
        step(1'b1, 2'b01, {$urandom, $urandom});
        check("uf_resume_seq", out_seq, 6'd10);
        for (int i = 0; i < 30; i++) step(1'b1, 2'b10, {$urandom, $urandom});
        check("uf_sticky", underflow_o, 1'b1);

        // Reset mid-sequence at seq 17, then alignment restarts at bit 0.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 2'b01, {$urandom, $urandom});
        do_reset();
        blkd = 64'h0123_4567_89AB_CDEF;
        step(1'b1, 2'b10, blkd);
        tmp = (blkd << 2) | 64'h2;
        check("post_rst_align", out_word, tmp);
        check("post_rst_seq", out_seq, 6'd0);

        // Block held through the drain slot is consumed one cycle later.
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 2'b01, {$urandom, $urandom});
        blkd = 64'hDEAD_BEEF_CAFE_F00D;
        check("drain_ready", ready_o, 1'b0);
        step(1'b1, 2'b10, blkd);
        check("drain_seq", out_seq, 6'd32);
        check("after_drain_ready", ready_o, 1'b1);
        step(1'b1, 2'b10, blkd);
        check("held_accept_seq", out_seq, 6'd0);
        tmp = (blkd << 2) | 64'h2;
        check("held_accept_data", out_word, tmp);
        step(1'b1, 2'b01, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
